// File: rtl/decoder_onehot_pipe.sv
// ---------------------------------------------------------------------------
// decoder_onehot_pipe
//
// Pipelined index-to-vector decoder with valid/ready handshakes on both
// sides. An IN_W-bit index is decoded into an OUT_W-bit vector in one of
// four modes (one-hot, thermometer, inverted one-hot, zero). Indices that
// fall outside the vector are flagged and counted in a saturating counter.
// A main output register (M) plus one skid register (S) sustain one result
// per cycle while keeping every output, including in_ready, registered.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   input item present
//   in_ready   block can accept an item this cycle (registered)
//   in_idx     index to decode
//   in_mode    0 one-hot, 1 thermometer, 2 inverted one-hot, 3 zero
//   out_valid  result present
//   out_ready  consumer accepts the result this cycle
//   out_vec    decoded vector
//   out_err    result came from an out-of-range index
//   err_cnt    saturating count of accepted out-of-range items
// ---------------------------------------------------------------------------
module decoder_onehot_pipe #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_idx,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_vec,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt
);

    // Occupancy of the two-entry buffer: nothing held, only M full, or
    // both M and S full.
    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } state_t;

    state_t           state;
    logic [OUT_W-1:0] s_vec;
    logic             s_err;
    logic [OUT_W-1:0] dec_vec;
    logic             dec_err;
    logic [31:0]      idx_u;
    logic             accept;
    logic             drain;

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    // Decode the incoming index before it is stored, so both M and S hold
    // finished vectors. An out-of-range index always yields a zero vector
    // with the error flag set, regardless of mode.
    always_comb begin
        dec_vec = '0;
        dec_err = 1'b0;
        idx_u   = 32'(in_idx);
        if (idx_u >= 32'(OUT_W)) begin
            dec_err = 1'b1;
        end else begin
            for (int i = 0; i < OUT_W; i++) begin
                case (in_mode)
                    2'd0:    dec_vec[i] = (idx_u == 32'(i));
                    2'd1:    dec_vec[i] = (32'(i) <= idx_u);
                    2'd2:    dec_vec[i] = (idx_u != 32'(i));
                    default: dec_vec[i] = 1'b0;
                endcase
            end
        end
    end

    // Buffer control, output registers and error counter. in_ready is kept
    // as its own register equal to "S will be empty after this edge", which
    // also holds it low during reset and raises it on the first edge after.
    // A simultaneous accept and drain with S empty simply reloads M, so
    // out_valid never drops while the stream is continuous.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            out_vec   <= '0;
            out_err   <= 1'b0;
            s_vec     <= '0;
            s_err     <= 1'b0;
            in_ready  <= 1'b0;
            err_cnt   <= '0;
        end else begin
            if (accept && dec_err && (err_cnt != {CNT_W{1'b1}})) begin
                err_cnt <= err_cnt + 1'b1;
            end

            in_ready <= 1'b1;

            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        out_vec   <= dec_vec;
                        out_err   <= dec_err;
                        out_valid <= 1'b1;
                        state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        out_vec <= dec_vec;
                        out_err <= dec_err;
                    end else if (accept) begin
                        s_vec    <= dec_vec;
                        s_err    <= dec_err;
                        in_ready <= 1'b0;
                        state    <= ST_TWO;
                    end else if (drain) begin
                        out_valid <= 1'b0;
                        state     <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        out_vec <= s_vec;
                        out_err <= s_err;
                        state   <= ST_ONE;
                    end else begin
                        in_ready <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_onehot_pipe.sv
// ---------------------------------------------------------------------------
// tb_decoder_onehot_pipe
//
// Drives two decoders from the same stimulus: one with default parameters
// (8 outputs, 8-bit counter) and one with 6 outputs and a 2-bit counter so
// that out-of-range indices and counter saturation occur. Both see the same
// handshake, so a single scoreboard queue holds the expected result of each
// accepted item for both instances.
// ---------------------------------------------------------------------------
module tb_decoder_onehot_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] in_idx = '0;
    logic [1:0] in_mode = '0;
    logic       out_ready = 1'b0;

    logic       in_ready_a, out_valid_a, out_err_a;
    logic [7:0] out_vec_a;
    logic [7:0] err_cnt_a;
    logic       in_ready_b, out_valid_b, out_err_b;
    logic [5:0] out_vec_b;
    logic [1:0] err_cnt_b;

    typedef struct {
        logic [63:0] va;
        logic        ea;
        logic [63:0] vb;
        logic        eb;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   exp_err_a = 0;
    int   exp_err_b = 0;
    bit   ready_up = 1'b0;

    decoder_onehot_pipe #(.IN_W(3), .OUT_W(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .in_idx(in_idx), .in_mode(in_mode),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_vec(out_vec_a), .out_err(out_err_a), .err_cnt(err_cnt_a)
    );

    decoder_onehot_pipe #(.IN_W(3), .OUT_W(6), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .in_idx(in_idx), .in_mode(in_mode),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_vec(out_vec_b), .out_err(out_err_b), .err_cnt(err_cnt_b)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Compare one observed value against the expected one and keep score.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: the expected vector is built with shifts and
    // masks straight from the mode definitions.
    function automatic void model(input int idx, input int mode, input int outw,
                                  output logic [63:0] vec, output logic err);
        logic [63:0] mask;
        mask = (64'd1 << outw) - 64'd1;
        if (idx >= outw) begin
            vec = '0;
            err = 1'b1;
        end else begin
            err = 1'b0;
            case (mode)
                0:       vec = 64'd1 << idx;
                1:       vec = (64'd2 << idx) - 64'd1;
                2:       vec = ~(64'd1 << idx) & mask;
                default: vec = '0;
            endcase
        end
    endfunction

    // One cycle of stimulus: drive inputs at the falling edge, check the
    // ready and counter outputs, and after the rising edge record an
    // accepted item in the scoreboard.
    task automatic applyStimulus(input bit v, input int idx, input int mode,
                                 input bit ord, output bit acc);
        bit   exp_rdy;
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_idx    = 3'(idx);
        in_mode   = 2'(mode);
        out_ready = ord;
        exp_rdy   = ready_up && (q.size() < 2);
        checkOutput("in_ready_a", 64'(in_ready_a), 64'(exp_rdy));
        checkOutput("in_ready_b", 64'(in_ready_b), 64'(exp_rdy));
        checkOutput("err_cnt_a", 64'(err_cnt_a), 64'(exp_err_a));
        checkOutput("err_cnt_b", 64'(err_cnt_b), 64'(exp_err_b));
        acc = v && exp_rdy;
        model(idx, mode, 8, e.va, e.ea);
        model(idx, mode, 6, e.vb, e.eb);
        @(posedge clk);
        if (acc) begin
            q.push_back(e);
            if (e.ea && exp_err_a < 255) exp_err_a++;
            if (e.eb && exp_err_b < 3) exp_err_b++;
        end
    endtask

    // Keep offering one item until it is accepted, within a cycle bound.
    task automatic sendItem(input int idx, input int mode, input bit ord);
        bit acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) begin
            applyStimulus(1'b1, idx, mode, ord, acc);
        end
        if (!acc) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL send_timeout: idx %0d never accepted, expected acceptance within 20 cycles", idx);
        end
    endtask

    // Hold reset for two edges, check the reset state of both instances,
    // then release and wait for the first edge with reset low.
    task automatic doReset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        q.delete();
        ready_up  = 1'b0;
        exp_err_a = 0;
        exp_err_b = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid_a", 64'(out_valid_a), 64'd0);
        checkOutput("rst_out_valid_b", 64'(out_valid_b), 64'd0);
        checkOutput("rst_out_vec_a", 64'(out_vec_a), 64'd0);
        checkOutput("rst_out_err_a", 64'(out_err_a), 64'd0);
        checkOutput("rst_err_cnt_a", 64'(err_cnt_a), 64'd0);
        checkOutput("rst_err_cnt_b", 64'(err_cnt_b), 64'd0);
        checkOutput("rst_in_ready_a", 64'(in_ready_a), 64'd0);
        checkOutput("rst_in_ready_b", 64'(in_ready_b), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        ready_up = 1'b1;
    endtask

    // Monitor: once per cycle, away from the rising edge, check out_valid
    // against scoreboard occupancy and compare the presented result against
    // the oldest expected item; pop it when the consumer takes it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                checkOutput("out_valid_a", 64'(out_valid_a), 64'(q.size() > 0));
                checkOutput("out_valid_b", 64'(out_valid_b), 64'(q.size() > 0));
                if (q.size() > 0 && out_valid_a) begin
                    e = q[0];
                    checkOutput("out_vec_a", 64'(out_vec_a), e.va);
                    checkOutput("out_err_a", 64'(out_err_a), 64'(e.ea));
                    checkOutput("out_vec_b", 64'(out_vec_b), e.vb);
                    checkOutput("out_err_b", 64'(out_err_b), 64'(e.eb));
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    // Main stimulus sequence.
    initial begin
        bit acc;
        doReset();

        $display("[TB] one-hot sweep");
        for (int i = 0; i < 8; i++) sendItem(i, 0, 1'b1);

        $display("[TB] modes at idx 5");
        for (int m = 1; m < 4; m++) sendItem(5, m, 1'b1);

        $display("[TB] out-of-range and counter saturation");
        sendItem(6, 1, 1'b1);
        sendItem(7, 0, 1'b1);
        for (int i = 0; i < 4; i++) sendItem(6 + (i % 2), i, 1'b1);
        repeat (3) applyStimulus(1'b0, 0, 0, 1'b1, acc);

        $display("[TB] back-pressure");
        sendItem(1, 0, 1'b0);
        sendItem(2, 0, 1'b0);
        repeat (3) applyStimulus(1'b1, 3, 0, 1'b0, acc);
        sendItem(3, 0, 1'b1);
        repeat (4) applyStimulus(1'b0, 0, 0, 1'b1, acc);

        $display("[TB] continuous streaming");
        for (int i = 0; i < 200; i++)
            applyStimulus(1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1'b1, acc);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++)
            applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 3)), $urandom_range(0, 2) != 0, acc);

        $display("[TB] reset with both entries full");
        repeat (4) applyStimulus(1'b0, 0, 0, 1'b1, acc);
        sendItem(4, 1, 1'b0);
        sendItem(6, 2, 1'b0);
        doReset();
        repeat (4) applyStimulus(1'b0, 0, 0, 1'b1, acc);
        sendItem(2, 1, 1'b1);

        repeat (5) applyStimulus(1'b0, 0, 0, 1'b1, acc);
        checkOutput("queue_empty", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
